// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_SEL_W = 5;
  localparam logic [REG_SEL_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_SEL_W-1:0] de_reg_1_sel;
  logic [REG_SEL_W-1:0] de_reg_2_sel;
  logic                 de_reg_1_read;
  logic                 de_reg_2_read;
  logic                 ex_mem_en;
  logic                 ex_mem_wrt;
  logic                 ex_reg_wrt_en;
  logic [REG_SEL_W-1:0] ex_reg_wrt_sel;
  logic                 ex_redirect;
  logic                 mem_req;
  logic                 mem_ready;

  logic                 pc_stall;
  logic                 fede_stall;
  logic                 fede_flush;
  logic                 deex_stall;
  logic                 deex_flush;
  logic                 exme_stall;
  logic                 mewb_flush;
  logic                 mem_timeout;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output de_reg_1_sel, de_reg_2_sel, de_reg_1_read, de_reg_2_read,
    output ex_mem_en, ex_mem_wrt, ex_reg_wrt_en, ex_reg_wrt_sel, ex_redirect,
    output mem_req, mem_ready,
    input  pc_stall, fede_stall, fede_flush, deex_stall, deex_flush,
    input  exme_stall, mewb_flush, mem_timeout, stall_count
  );

  modport slave (
    input  de_reg_1_sel, de_reg_2_sel, de_reg_1_read, de_reg_2_read,
    input  ex_mem_en, ex_mem_wrt, ex_reg_wrt_en, ex_reg_wrt_sel, ex_redirect,
    input  mem_req, mem_ready,
    output pc_stall, fede_stall, fede_flush, deex_stall, deex_flush,
    output exme_stall, mewb_flush, mem_timeout, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags a decode-stage read of a register that the load currently in DeEx will write.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_SEL_W-1:0] de_reg_1_sel,
  input  logic [REG_SEL_W-1:0] de_reg_2_sel,
  input  logic                 de_reg_1_read,
  input  logic                 de_reg_2_read,
  input  logic                 ex_mem_en,
  input  logic                 ex_mem_wrt,
  input  logic                 ex_reg_wrt_en,
  input  logic [REG_SEL_W-1:0] ex_reg_wrt_sel,
  output logic                 load_use
);

  logic is_load;
  logic hit_1;
  logic hit_2;

  always_comb begin
    is_load  = ex_mem_en & ~ex_mem_wrt & ex_reg_wrt_en & (ex_reg_wrt_sel != REG_ZERO);
    hit_1    = de_reg_1_read & (de_reg_1_sel == ex_reg_wrt_sel);
    hit_2    = de_reg_2_read & (de_reg_2_sel == ex_reg_wrt_sel);
    load_use = is_load & (hit_1 | hit_2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for FeDe, DeEx, ExMe and MeWb: memory wait > redirect > load-use.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_MEM_WAIT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int unsigned RC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WC_W = $clog2(MAX_MEM_WAIT + 1);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              timeout_q;
  logic              timeout_set;
  logic [CNT_W-1:0]  count_q;

  logic load_use;
  logic mem_block;
  logic eval_run;
  logic pc_stall, fede_stall, fede_flush, deex_stall, deex_flush, exme_stall, mewb_flush;

  load_use_detect u_load_use (
    .de_reg_1_sel   (bus.de_reg_1_sel),
    .de_reg_2_sel   (bus.de_reg_2_sel),
    .de_reg_1_read  (bus.de_reg_1_read),
    .de_reg_2_read  (bus.de_reg_2_read),
    .ex_mem_en      (bus.ex_mem_en),
    .ex_mem_wrt     (bus.ex_mem_wrt),
    .ex_reg_wrt_en  (bus.ex_reg_wrt_en),
    .ex_reg_wrt_sel (bus.ex_reg_wrt_sel),
    .load_use       (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      if (timeout_set)
        timeout_q <= 1'b1;
      if (pc_stall && (count_q != '1))
        count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    wcnt_d      = wcnt_q;
    timeout_set = 1'b0;
    eval_run    = 1'b0;
    pc_stall    = 1'b0;
    fede_stall  = 1'b0;
    fede_flush  = 1'b0;
    deex_stall  = 1'b0;
    deex_flush  = 1'b0;
    exme_stall  = 1'b0;
    mewb_flush  = 1'b0;
    mem_block   = bus.mem_req & ~bus.mem_ready;

    case (state_q)
      RUN: begin
        if (mem_block) begin
          {pc_stall, fede_stall, deex_stall, exme_stall, mewb_flush} = '1;
          state_d = MEM_WAIT;
          wcnt_d  = WC_W'(1);
        end else begin
          eval_run = 1'b1;
        end
      end
      // Completion and timeout both release EX in this cycle, so the held
      // redirect/load-use must be acted on now rather than a cycle later.
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d  = RUN;
          eval_run = 1'b1;
        end else if (wcnt_q >= WC_W'(MAX_MEM_WAIT)) begin
          timeout_set = 1'b1;
          state_d     = RUN;
          eval_run    = 1'b1;
        end else begin
          {pc_stall, fede_stall, deex_stall, exme_stall, mewb_flush} = '1;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      REDIRECT: begin
        if (mem_block) begin
          {pc_stall, fede_stall, deex_stall, exme_stall, mewb_flush} = '1;
          state_d = MEM_WAIT;
          wcnt_d  = WC_W'(1);
        end else begin
          fede_flush = 1'b1;
          if (rcnt_q <= RC_W'(1))
            state_d = RUN;
          else
            rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (eval_run) begin
      if (bus.ex_redirect) begin
        fede_flush = 1'b1;
        deex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = REDIRECT;
          rcnt_d  = RC_W'(FLUSH_CYCLES - 1);
        end
      end else if (load_use) begin
        pc_stall   = 1'b1;
        fede_stall = 1'b1;
        deex_flush = 1'b1;
      end
    end

    fede_stall = fede_stall & ~fede_flush;
    deex_stall = deex_stall & ~deex_flush;

    if (rst) begin
      {pc_stall, fede_stall, deex_stall, exme_stall} = '0;
      {fede_flush, deex_flush, mewb_flush}           = '1;
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.fede_stall  = fede_stall;
  assign bus.fede_flush  = fede_flush;
  assign bus.deex_stall  = deex_stall;
  assign bus.deex_flush  = deex_flush;
  assign bus.exme_stall  = exme_stall;
  assign bus.mewb_flush  = mewb_flush;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FC    = 3;
  localparam int unsigned MAXW  = 8;
  localparam int unsigned CW    = 6;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (FC),
    .MAX_MEM_WAIT (MAXW),
    .CNT_W        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] r1, r2, wsel;
  logic       rd1, rd2, men, mwr, wen, redir, req, rdy, rst_v;

  // model state: cycles already waited on memory (0 = not waiting),
  // extra FeDe flush cycles still owed, sticky timeout, stall counter
  int m_wait = 0, m_flush_left = 0, m_count = 0;
  bit m_timeout = 0;
  int n_wait, n_flush_left, n_count;
  bit n_timeout;
  bit primed = 0;

  logic [7:0] exp_ctl;
  int         exp_count;

  function automatic logic [7:0] obs_ctl();
    return {bus.pc_stall, bus.fede_stall, bus.fede_flush, bus.deex_stall,
            bus.deex_flush, bus.exme_stall, bus.mewb_flush, bus.mem_timeout};
  endfunction

  task automatic idle();
    r1 = 0; r2 = 0; wsel = 0; rd1 = 0; rd2 = 0; men = 0; mwr = 0; wen = 0;
    redir = 0; req = 0; rdy = 0; rst_v = 0;
  endtask

  task automatic model_eval();
    bit lu, free, ps, fs, ff, ds, df, es, mf;
    lu = men && !mwr && wen && (wsel != 0) &&
         ((rd1 && r1 == wsel) || (rd2 && r2 == wsel));
    {ps, fs, ff, ds, df, es, mf} = '0;
    free = 0;
    if (rst_v) begin
      ff = 1; df = 1; mf = 1;
      n_wait = 0; n_flush_left = 0; n_timeout = 0; n_count = 0;
    end else begin
      n_wait = m_wait; n_flush_left = m_flush_left; n_timeout = m_timeout; n_count = m_count;
      if (m_wait > 0) begin
        if (rdy) free = 1;
        else if (m_wait >= MAXW) begin n_timeout = 1; free = 1; end
        else begin ps = 1; fs = 1; ds = 1; es = 1; mf = 1; n_wait = m_wait + 1; end
      end else if (req && !rdy) begin
        ps = 1; fs = 1; ds = 1; es = 1; mf = 1; n_wait = 1; n_flush_left = 0;
      end else if (m_flush_left > 0) begin
        ff = 1; n_flush_left = m_flush_left - 1;
      end else begin
        free = 1;
      end
      if (free) begin
        n_wait = 0;
        if (redir) begin ff = 1; df = 1; n_flush_left = FC - 1; end
        else if (lu) begin ps = 1; fs = 1; df = 1; end
      end
      if (ps && m_count < CMAX) n_count = m_count + 1;
    end
    exp_ctl   = {ps, fs, ff, ds, df, es, mf, m_timeout};
    exp_count = m_count;
  endtask

  // Drive one cycle's inputs at the falling edge and settle the model's expectation.
  task automatic drive();
    if (primed) begin
      m_wait = n_wait; m_flush_left = n_flush_left; m_timeout = n_timeout; m_count = n_count;
    end
    primed = 1;
    @(negedge clk);
    rst = rst_v;
    bus.de_reg_1_sel = r1;  bus.de_reg_2_sel = r2;
    bus.de_reg_1_read = rd1; bus.de_reg_2_read = rd2;
    bus.ex_mem_en = men; bus.ex_mem_wrt = mwr; bus.ex_reg_wrt_en = wen;
    bus.ex_reg_wrt_sel = wsel; bus.ex_redirect = redir;
    bus.mem_req = req; bus.mem_ready = rdy;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    idle(); rst_v = 1; drive(); drive(); idle(); drive();
  endtask

  task automatic test_reset();
    idle(); rst_v = 1;
    for (int i = 0; i < 2; i++) begin
      drive();
      if (obs_ctl() !== 8'b0010_1010) begin
        errors++; $display("FAIL reset_ctl cyc%0d got=%b want=%b", i, obs_ctl(), 8'b0010_1010);
      end
      checks++;
    end
    if (bus.stall_count !== '0) begin
      errors++; $display("FAIL reset_count got=%0d want=0", bus.stall_count);
    end
    checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      men = 1; mwr = 0; wen = 1; wsel = 5; r2 = 5; rd2 = 1; r1 = 3; rd1 = 1;
      case (c)
        1: begin wsel = 0; r2 = 0; end
        2: begin r2 = 7; r1 = 5; end
        3: mwr = 1;
        4: rd2 = 0;
        5: wen = 0;
        default: ;
      endcase
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL load_use case%0d got=%b want=%b", c, obs_ctl(), exp_ctl);
      end
      checks++;
      idle(); drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL load_use_after case%0d got=%b want=%b", c, obs_ctl(), exp_ctl);
      end
      checks++;
    end
  endtask

  task automatic test_redirect();
    int ff_n, df_n;
    do_reset();
    ff_n = 0; df_n = 0;
    for (int i = 0; i < 5; i++) begin
      idle(); redir = (i == 0);
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL redirect cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl);
      end
      checks++;
      ff_n += int'(bus.fede_flush);
      df_n += int'(bus.deex_flush);
    end
    if (ff_n != 3 || df_n != 1) begin
      errors++; $display("FAIL redirect_len fede=%0d deex=%0d want=3/1", ff_n, df_n);
    end
    checks++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle(); req = (i < 5); rdy = (i == 4);
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL mem_wait cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl);
      end
      checks++;
    end
    if (bus.stall_count !== CW'(4)) begin
      errors++; $display("FAIL mem_wait_count got=%0d want=4", bus.stall_count);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      men = 1; wen = 1; wsel = 9; r1 = 9; rd1 = 1;
      req = (i <= 2); rdy = (i == 2); redir = (i <= 2);
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL simultaneous cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl);
      end
      checks++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle(); req = (i < 9);
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL timeout cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl);
      end
      checks++;
    end
    if (bus.mem_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky got=%b want=1", bus.mem_timeout);
    end
    checks++;
    do_reset();
    if (bus.mem_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got=%b want=0", bus.mem_timeout);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(); req = 1; drive(); drive();
    rst_v = 1; drive();
    if (obs_ctl() !== 8'b0010_1010) begin
      errors++; $display("FAIL reset_mid_ctl got=%b want=%b", obs_ctl(), 8'b0010_1010);
    end
    checks++;
    idle(); drive();
    if (obs_ctl() !== exp_ctl || bus.stall_count !== '0) begin
      errors++; $display("FAIL reset_mid_after ctl=%b want=%b count=%0d want=0",
                         obs_ctl(), exp_ctl, bus.stall_count);
    end
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst_v = ($urandom_range(0, 59) == 0);
      r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      wsel = 5'($urandom_range(0, 3));
      rd1 = 1'($urandom); rd2 = 1'($urandom);
      men = 1'($urandom); mwr = ($urandom_range(0, 3) == 0); wen = 1'($urandom);
      redir = ($urandom_range(0, 5) == 0);
      req = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 4) == 0);
      drive();
      if (obs_ctl() !== exp_ctl) begin
        errors++; $display("FAIL random_ctl cyc%0d got=%b want=%b", i, obs_ctl(), exp_ctl);
      end
      checks++;
      if (bus.stall_count !== CW'(exp_count)) begin
        errors++; $display("FAIL random_count cyc%0d got=%0d want=%0d", i, bus.stall_count, exp_count);
      end
      checks++;
    end
  endtask

  initial begin
    idle(); rst_v = 1;
    bus.de_reg_1_sel = '0; bus.de_reg_2_sel = '0; bus.de_reg_1_read = 0; bus.de_reg_2_read = 0;
    bus.ex_mem_en = 0; bus.ex_mem_wrt = 0; bus.ex_reg_wrt_en = 0; bus.ex_reg_wrt_sel = '0;
    bus.ex_redirect = 0; bus.mem_req = 0; bus.mem_ready = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
